// File: rtl/weight_load_sched.sv
// Weight-load scheduler: walks a run of filters through load, PE output and
// buffer-free rounds, issuing 8-byte reads under a bounded outstanding window.
package weight_load_sched_pkg;
  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } op_mode_e;
endpackage

// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start; run parameters latched on start
// LOAD      | issuing reads and counting returned beats into the buffer
// WAIT_PE   | buffer full, holding load enable until the PE array is idle
// OUTPUT    | streaming the filter out of the buffer into the PE array
// WAIT_DONE | output finished, waiting for PE compute completion
// FREE      | one-cycle buffer clear, then next filter or finish
// FINISH    | one-cycle done pulse back to the layer controller
module weight_load_sched
  import weight_load_sched_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  op_mode_e          cur_mode,
  input  logic              start,
  input  logic [ADDR_W-1:0] filter_base_addr,
  input  logic [ADDR_W-1:0] filter_stride,
  input  logic [CNT_W-1:0]  num_filters,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_data_valid,
  input  logic              wb_mem_req,
  input  logic              wb_ready_to_output,
  input  logic              wb_finish_output,
  output logic              wb_start_load,
  output logic              wb_output_filter,
  output logic              wb_free,
  input  logic              pe_ready,
  input  logic              pe_compute_done,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  filter_idx
);

  localparam int BEAT_W = 7;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_PE   = 3'd2,
    S_OUTPUT    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_FREE      = 3'd5,
    S_FINISH    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  op_mode_e            mode_q, mode_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    filter_idx_q, filter_idx_d;
  logic [BEAT_W-1:0]   issued_q, issued_d;
  logic [BEAT_W-1:0]   returned_q, returned_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic                done_seen_q, done_seen_d;

  logic [BEAT_W-1:0]   beats;
  logic                can_issue;
  logic                grant;
  logic                ret;

  // The buffer's own data request mirrors our issue accounting; not needed here.
  logic unused_wb_mem_req;
  assign unused_wb_mem_req = wb_mem_req;

  always_comb begin
    beats = 7'd11;
    case (mode_q)
      MODE1, MODE2: beats = 7'd88;
      MODE3:        beats = 7'd19;
      default:      beats = 7'd11;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    cur_addr_d       = cur_addr_q;
    stride_d         = stride_q;
    num_d            = num_q;
    filter_idx_d     = filter_idx_q;
    issued_d         = issued_q;
    returned_d       = returned_q;
    outstanding_d    = outstanding_q;
    done_seen_d      = done_seen_q;
    mem_rd_req       = 1'b0;
    wb_start_load    = 1'b0;
    wb_output_filter = 1'b0;
    wb_free          = 1'b0;
    done             = 1'b0;
    can_issue        = (issued_q < beats) && (outstanding_q < OUT_MAX);
    grant            = 1'b0;
    ret              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d        = cur_mode;
          cur_addr_d    = filter_base_addr;
          stride_d      = filter_stride;
          num_d         = num_filters;
          filter_idx_d  = '0;
          issued_d      = '0;
          returned_d    = '0;
          outstanding_d = '0;
          done_seen_d   = 1'b0;
          state_d       = (num_filters == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        wb_start_load = 1'b1;
        mem_rd_req    = can_issue;
        grant         = can_issue && mem_rd_gnt;
        // Beats beyond the filter's count never reach the counters.
        ret           = mem_data_valid && (returned_q < beats) && (outstanding_q != '0);
        if (grant) issued_d = issued_q + BEAT_W'(1);
        if (ret) returned_d = returned_q + BEAT_W'(1);
        outstanding_d = outstanding_q + OUT_W'(grant) - OUT_W'(ret);
        if (wb_ready_to_output && (returned_q == beats)) state_d = S_WAIT_PE;
      end
      S_WAIT_PE: begin
        wb_start_load = 1'b1;
        if (pe_ready) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        wb_start_load    = 1'b1;
        wb_output_filter = 1'b1;
        if (pe_compute_done) done_seen_d = 1'b1;
        if (wb_finish_output) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        wb_start_load = 1'b1;
        if (done_seen_q || pe_compute_done) state_d = S_FREE;
      end
      S_FREE: begin
        wb_free       = 1'b1;
        issued_d      = '0;
        returned_d    = '0;
        outstanding_d = '0;
        done_seen_d   = 1'b0;
        if (filter_idx_q == num_q - CNT_W'(1)) begin
          state_d = S_FINISH;
        end else begin
          filter_idx_d = filter_idx_q + CNT_W'(1);
          cur_addr_d   = cur_addr_q + stride_q;
          state_d      = S_LOAD;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE1;
      cur_addr_q    <= '0;
      stride_q      <= '0;
      num_q         <= '0;
      filter_idx_q  <= '0;
      issued_q      <= '0;
      returned_q    <= '0;
      outstanding_q <= '0;
      done_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cur_addr_q    <= cur_addr_d;
      stride_q      <= stride_d;
      num_q         <= num_d;
      filter_idx_q  <= filter_idx_d;
      issued_q      <= issued_d;
      returned_q    <= returned_d;
      outstanding_q <= outstanding_d;
      done_seen_q   <= done_seen_d;
    end
  end

  // Address only presented while loading so it reads zero everywhere else.
  assign mem_rd_addr = (state_q == S_LOAD)
                     ? cur_addr_q + ADDR_W'({issued_q, 3'b000})
                     : '0;
  assign busy        = (state_q != S_IDLE);
  assign filter_idx  = filter_idx_q;

endmodule

// File: tb/tb_weight_load_sched.sv
// Bench for weight_load_sched: responders for memory, buffer and PE array plus
// a transaction-level model (expected address stream, outstanding count, pulses).
`timescale 1ns/1ps
module tb_weight_load_sched;
  import weight_load_sched_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 8;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  op_mode_e          cur_mode = MODE1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] filter_base_addr = '0;
  logic [ADDR_W-1:0] filter_stride = '0;
  logic [CNT_W-1:0]  num_filters = '0;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_gnt = 1'b0;
  logic              mem_data_valid = 1'b0;
  logic              wb_mem_req = 1'b0;
  logic              wb_ready_to_output = 1'b0;
  logic              wb_finish_output = 1'b0;
  logic              wb_start_load;
  logic              wb_output_filter;
  logic              wb_free;
  logic              pe_ready = 1'b0;
  logic              pe_compute_done = 1'b0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  filter_idx;

  weight_load_sched #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cur_mode(cur_mode), .start(start),
    .filter_base_addr(filter_base_addr), .filter_stride(filter_stride),
    .num_filters(num_filters), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_gnt(mem_rd_gnt), .mem_data_valid(mem_data_valid), .wb_mem_req(wb_mem_req),
    .wb_ready_to_output(wb_ready_to_output), .wb_finish_output(wb_finish_output),
    .wb_start_load(wb_start_load), .wb_output_filter(wb_output_filter), .wb_free(wb_free),
    .pe_ready(pe_ready), .pe_compute_done(pe_compute_done), .busy(busy), .done(done),
    .filter_idx(filter_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // responder knobs
  int               lat = 2;
  int               beats_exp = 11;
  int               pe_delay = 0;
  int               out_len = 3;
  int               cd_delay = 1;
  bit               pe_early = 1'b0;
  logic [ADDR_W-1:0] stall_addr = '0;
  int               stall_len = 0;
  bit               stall_used = 1'b0;

  // model / scoreboard state
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] glog[$];
  int exp_total = 0, grants = 0, stalls = 0, out_b = 0, max_out = 0;
  int frees_run = 0, dones = 0;
  int start_cyc = -1, free_cyc = -1, done_cyc = -1, fin_cyc = -1;
  int out_start_cyc = -1, pe_first_cyc = -1;

  function automatic longint glog_at(input int i);
    if (i < glog.size()) return longint'(glog[i]);
    return -1;
  endfunction

  function automatic int beats_of(input op_mode_e m);
    case (m)
      MODE1, MODE2: return 88;
      MODE3:        return 19;
      default:      return 11;
    endcase
  endfunction

  // Memory, weight-buffer and PE-array responders; drive 2 ns after the edge.
  int ret_q[$];
  int wb_cnt = 0, pe_cnt = 0, out_cnt = 0, cd_cnt = -1, stall_left = 0;
  always @(posedge clk) begin
    #2;
    mem_data_valid = 1'b0;
    if (ret_q.size() > 0) begin
      if (ret_q[0] == cyc) begin
        mem_data_valid = 1'b1;
        void'(ret_q.pop_front());
      end
    end
    if (mem_rd_req && stall_len > 0 && !stall_used && mem_rd_addr == stall_addr) begin
      stall_used = 1'b1;
      stall_left = stall_len;
    end
    mem_rd_gnt = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    if (mem_rd_req && mem_rd_gnt) ret_q.push_back(cyc + lat);

    if (!rst_n) begin
      wb_cnt = 0; pe_cnt = 0; out_cnt = 0; cd_cnt = -1;
    end
    wb_ready_to_output = wb_start_load && (wb_cnt >= beats_exp);
    wb_mem_req         = wb_start_load && (wb_cnt < beats_exp);
    if (mem_data_valid && wb_start_load) wb_cnt++;

    pe_ready = wb_ready_to_output && !wb_output_filter && (pe_cnt >= pe_delay);
    if (wb_ready_to_output && !wb_output_filter) pe_cnt++;

    wb_finish_output = wb_output_filter && (out_cnt == out_len);
    pe_compute_done  = 1'b0;
    if (pe_early) pe_compute_done = wb_output_filter && (out_cnt == 1);
    else if (cd_cnt == 0) pe_compute_done = 1'b1;
    if (cd_cnt >= 0) cd_cnt--;
    if (wb_finish_output && !pe_early) cd_cnt = cd_delay;
    if (wb_output_filter) out_cnt++;
    if (wb_free) begin
      wb_cnt = 0; pe_cnt = 0; out_cnt = 0;
    end
  end

  // Compare process: every live cycle, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy) start_cyc = cyc;
      if (mem_rd_req && mem_rd_gnt) begin
        grants++;
        glog.push_back(mem_rd_addr);
        if (exp_q.size() == 0) chk("request_overrun", grants, exp_total);
        else chk("rd_addr", mem_rd_addr, exp_q.pop_front());
      end
      if (mem_rd_req && !mem_rd_gnt && stall_len > 0) begin
        stalls++;
        chk("stall_addr_hold", mem_rd_addr, stall_addr);
      end
      if (mem_rd_req && mem_rd_gnt) out_b++;
      if (mem_data_valid && out_b > 0) out_b--;
      if (out_b > max_out) max_out = out_b;
      if (busy) begin
        chk("outstanding_limit", out_b > MAX_OUT, 0);
        chk("req_scope", mem_rd_req && !(wb_start_load && !wb_output_filter), 0);
        chk("outfilt_scope", wb_output_filter && !wb_start_load, 0);
        chk("free_exclusive", wb_free && (wb_start_load || mem_rd_req || done), 0);
        if (wb_start_load) chk("filter_idx", filter_idx, frees_run);
      end else begin
        chk("idle_quiet", {mem_rd_req, wb_start_load, wb_output_filter, wb_free, done}, 0);
      end
      if (wb_free) begin frees_run++; free_cyc = cyc; end
      if (wb_output_filter && out_start_cyc < 0) out_start_cyc = cyc;
      if (pe_ready && pe_first_cyc < 0) pe_first_cyc = cyc;
      if (wb_finish_output) fin_cyc = cyc;
      if (done) begin dones++; done_cyc = cyc; end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input op_mode_e m, input logic [ADDR_W-1:0] base,
                        input logic [ADDR_W-1:0] stride, input int n);
    logic [ADDR_W-1:0] a;
    cur_mode = m; filter_base_addr = base; filter_stride = stride;
    num_filters = CNT_W'(n); beats_exp = beats_of(m);
    exp_q.delete(); glog.delete();
    for (int f = 0; f < n; f++)
      for (int i = 0; i < beats_exp; i++) begin
        a = base + ADDR_W'(f) * stride + ADDR_W'(8 * i);
        exp_q.push_back(a);
      end
    exp_total = n * beats_exp;
    grants = 0; stalls = 0; max_out = 0; frees_run = 0; dones = 0;
    free_cyc = -1; done_cyc = -1; fin_cyc = -1; out_start_cyc = -1; pe_first_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (dones == 0 && k < budget) begin tick(); k++; end
    tick(2);
    chk({name, "_done_once"}, dones, 1);
    chk({name, "_addr_stream_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req"}, mem_rd_req, 0);
    chk({name, "_addr"}, mem_rd_addr, 0);
    chk({name, "_load_out_free"}, {wb_start_load, wb_output_filter, wb_free}, 0);
    chk({name, "_busy_done"}, {busy, done}, 0);
    chk({name, "_filter_idx"}, filter_idx, 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // 1: MODE4, single filter, WAIT_PE held by pe_ready
    lat = 2; pe_delay = 3; out_len = 3; cd_delay = 1; pe_early = 1'b0;
    launch(MODE4, 32'h1000, 32'h100, 1);
    wait_done("t1", 400);
    chk("t1_req_count", grants, 11);
    chk("t1_first_addr", glog_at(0), 32'h1000);
    chk("t1_last_addr", glog_at(10), 32'h1050);
    chk("t1_output_after_pe_ready", out_start_cyc, pe_first_cyc + 1);
    chk("t1_free_count", frees_run, 1);
    chk("t1_done_after_free", done_cyc, free_cyc + 1);
    tick(3);

    // 2: MODE1, three filters, long latency fills the outstanding window
    lat = 6; pe_delay = 0;
    launch(MODE1, 32'h0, 32'h200, 3);
    wait_done("t2", 4000);
    chk("t2_req_count", grants, 264);
    chk("t2_f2_first_addr", glog_at(176), 32'h400);
    chk("t2_f2_last_addr", glog_at(263), 32'h6B8);
    chk("t2_free_count", frees_run, 3);
    chk("t2_max_outstanding", max_out, 4);
    chk("t2_done_after_free", done_cyc, free_cyc + 1);
    tick(3);

    // 3: MODE3 with grant held low for 5 cycles on beat 7
    lat = 2; stall_addr = 32'h2038; stall_len = 5; stall_used = 1'b0;
    launch(MODE3, 32'h2000, 32'h40, 1);
    wait_done("t3", 600);
    chk("t3_req_count", grants, 19);
    chk("t3_stall_cycles", stalls, 5);
    chk("t3_beat7_addr", glog_at(7), 32'h2038);
    chk("t3_beat8_addr", glog_at(8), 32'h2040);
    stall_len = 0;
    tick(3);

    // 4: compute-done arrives during OUTPUT; start while busy is ignored
    pe_early = 1'b1; out_len = 4;
    launch(MODE4, 32'h3000, 32'h80, 2);
    tick(6);
    cur_mode = MODE1; filter_base_addr = 32'hF000; num_filters = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", 800);
    chk("t4_req_count", grants, 22);
    chk("t4_f1_first_addr", glog_at(11), 32'h3080);
    chk("t4_free_two_after_finish", free_cyc, fin_cyc + 2);
    chk("t4_free_count", frees_run, 2);
    pe_early = 1'b0; out_len = 3;
    tick(3);

    // 5: empty run
    launch(MODE2, 32'h5000, 32'h0, 0);
    wait_done("t5", 20);
    chk("t5_done_latency", done_cyc, start_cyc + 1);
    chk("t5_req_count", grants, 0);
    chk("t5_free_count", frees_run, 0);
    tick(3);

    // 6: reset mid-LOAD, then clean restart
    lat = 2;
    launch(MODE4, 32'h6000, 32'h100, 1);
    k = 0;
    while (grants < 5 && k < 100) begin tick(); k++; end
    chk("t6_reached_5_grants", grants >= 5, 1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t6_reset");
    rst_n = 1'b1;
    exp_q.delete(); out_b = 0;
    tick(8);
    launch(MODE4, 32'h6000, 32'h100, 1);
    wait_done("t6", 400);
    chk("t6_req_count", grants, 11);
    chk("t6_first_addr", glog_at(0), 32'h6000);
    chk("t6_last_addr", glog_at(10), 32'h6050);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_load_sched.md
Name: weight_load_sched

Overview:
Sequences the weight buffer through repeated load / output / free rounds for a run of filters. Per filter it:
- issues 8-byte memory read addresses;
- holds the buffer's load enable until the buffer reports full;
- waits for the PE array, triggers filter output and waits for PE compute completion;
- frees the buffer and advances to the next filter.

Sits between the layer controller (start/done), the memory read port, the weight buffer and the PE array.

Parameters:
ADDR_W, 32, memory byte-address width
MAX_OUTSTANDING, 4, maximum issued-but-unreturned read beats (power of 2, 2..16)
CNT_W, 8, width of filter count and filter index

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cur_mode  in  OP_MODE  MODE1..MODE4; sampled at start, held internally for the run
start  in  1  one-cycle pulse, begin run; ignored unless state is IDLE
filter_base_addr  in  ADDR_W  byte address of filter 0; sampled at start
filter_stride  in  ADDR_W  byte distance between consecutive filters; sampled at start
num_filters  in  CNT_W  filters in run; sampled at start
mem_rd_req  out  1  read request valid
mem_rd_addr  out  ADDR_W  read byte address, 8-byte aligned
mem_rd_gnt  in  1  request accepted this cycle when mem_rd_req=1
mem_data_valid  in  1  8-byte read beat returns (same wire feeds weight buffer)
wb_mem_req  in  1  weight buffer still needs data
wb_ready_to_output  in  1  weight buffer full
wb_finish_output  in  1  weight buffer output sequence complete (delayed finish pulse)
wb_start_load  out  1  load enable to weight buffer
wb_output_filter  out  1  output enable to weight buffer
wb_free  out  1  clear weight buffer, one-cycle pulse
pe_ready  in  1  PE array idle, can accept new filter
pe_compute_done  in  1  PE array finished current filter, pulse
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run
filter_idx  out  CNT_W  index of filter in progress

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. All outputs 0; mem_rd_addr=0. Counters and latches cleared. Mid-run reset abandons the run. Beats returning after reset are ignored because they are only counted in LOAD.
- Beats per filter BEATS: MODE1, MODE2 = 88 (44 rows x 2 beats); MODE3 = 19; MODE4 = 11.
- States: IDLE, LOAD, WAIT_PE, OUTPUT, WAIT_DONE, FREE, FINISH.
- IDLE:
  - start with num_filters=0 -> FINISH.
  - start with num_filters>0 -> LOAD, filter_idx=0, cur_addr=filter_base_addr.
- LOAD:
  - wb_start_load=1.
  - mem_rd_req=1 while issued<BEATS and outstanding<MAX_OUTSTANDING.
  - mem_rd_addr = cur_addr + 8*issued.
  - Handshake mem_rd_req&&mem_rd_gnt: issued++, outstanding++.
  - mem_data_valid in LOAD: returned++, outstanding--. Same-cycle grant+return leaves outstanding unchanged.
  - Returns when returned==BEATS are ignored (no underflow).
  - mem_rd_addr holds stable while mem_rd_req=1 and not granted.
  - Exit when wb_ready_to_output=1 and returned==BEATS -> WAIT_PE.
- WAIT_PE:
  - wb_start_load stays 1, required to keep wb_ready_to_output asserted.
  - pe_ready=1 -> OUTPUT.
- OUTPUT:
  - wb_start_load=1, wb_output_filter=1.
  - wb_finish_output=1 -> WAIT_DONE; wb_output_filter drops the next cycle.
- WAIT_DONE:
  - wb_start_load=1.
  - Leave on pe_compute_done -> FREE.
  - A pe_compute_done seen in OUTPUT is latched in done_seen. If done_seen=1, WAIT_DONE exits on its first cycle.
  - done_seen clears in FREE.
- FREE:
  - Exactly one cycle; wb_free=1, wb_start_load=0.
  - Clears issued, returned, outstanding.
  - If filter_idx==num_filters-1 -> FINISH.
  - Else filter_idx++, cur_addr += filter_stride (wraps modulo 2^ADDR_W) -> LOAD.
- FINISH: done=1 for one cycle -> IDLE.
- Mode and run parameters are sampled only at start. Changes to inputs mid-run have no effect.
- mem_rd_req is never asserted outside LOAD.
- wb_output_filter is never asserted outside OUTPUT.

Test Plan:
1. MODE4, base 0x1000, num_filters=1, gnt always 1, data 2 cycles after grant:
   - 11 requests at addresses 0x1000, 0x1008 ... 0x1050;
   - outstanding never exceeds 4;
   - WAIT_PE, then OUTPUT after pe_ready, then wb_free pulse;
   - done one cycle after FREE.
2. MODE1, num_filters=3, stride 0x200, base 0:
   - 88 requests per filter;
   - filter 2 first address 0x400, last address 0x400+87*8=0x6B8;
   - exactly 3 wb_free pulses and 1 done.
3. Backpressure, MODE3, gnt low for 5 cycles on beat 7:
   - mem_rd_addr held at base+0x38 throughout;
   - 19 beats total, no duplicate or skipped address.
4. pe_compute_done pulsed in OUTPUT before wb_finish_output:
   - WAIT_DONE lasts 1 cycle, then FREE;
   - start pulsed while busy is ignored.
5. num_filters=0 -> done one cycle after start, no mem_rd_req.
6. Reset in LOAD after 5 grants:
   - all outputs 0 next cycle;
   - late mem_data_valid ignored;
   - a new start restarts from filter_base_addr with a clean count.
